// File: rtl/act_rr_arbiter.sv
// Round-robin arbiter that shares one activation stage between NUM_CH streams.
// A channel holds the grant for up to BURST_LEN beats; the output is one register stage.

module act_rr_slot #(
    parameter int DATA_WIDTH = 12,
    parameter int CH_WIDTH   = 2,
    parameter int IDX        = 0
) (
    input  logic [CH_WIDTH-1:0]   sel,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_gated
);
    logic hit;

    assign hit        = (sel == CH_WIDTH'(IDX));
    assign ready      = en & hit;
    // Zero when not selected so the top can OR all slots into one mux
    assign data_gated = hit ? data : '0;
endmodule

module act_rr_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 12,
    parameter int BURST_LEN  = 8,
    parameter int CH_WIDTH   = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            arb_valid_in,
    output logic [NUM_CH-1:0]            arb_ready_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] arb_data_in,
    input  logic                         arb_ready_out,
    output logic                         arb_valid_out,
    output logic [DATA_WIDTH-1:0]        arb_data_out,
    output logic [CH_WIDTH-1:0]          arb_ch_out,
    output logic                         arb_last_out
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_n;
    logic [CH_WIDTH-1:0]   grant_ch, grant_n;
    logic [CH_WIDTH-1:0]   rr_ptr, rr_n;
    logic [CNT_W-1:0]      beat_cnt, cnt_n;

    logic                  adv, any_valid, en, xfer, at_last;
    logic [CH_WIDTH-1:0]   search_sel, sel;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_gated;

    function automatic logic [CH_WIDTH-1:0] next_ch(input logic [CH_WIDTH-1:0] c);
        return (c == CH_WIDTH'(NUM_CH - 1)) ? '0 : c + CH_WIDTH'(1);
    endfunction

    assign adv       = arb_ready_out | ~arb_valid_out;
    assign any_valid = |arb_valid_in;

    // First valid channel scanning upward from rr_ptr with wrap
    always_comb begin
        logic                found;
        logic [CH_WIDTH-1:0] idx;
        search_sel = rr_ptr;
        found      = 1'b0;
        idx        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_WIDTH'((int'(rr_ptr) + i) % NUM_CH);
            if (!found && arb_valid_in[idx]) begin
                search_sel = idx;
                found      = 1'b1;
            end
        end
    end

    assign sel = (state == BURST) ? grant_ch : search_sel;
    assign en  = ~rst & adv & ((state == BURST) | any_valid);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        act_rr_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .CH_WIDTH   (CH_WIDTH),
            .IDX        (k)
        ) u_slot (
            .sel        (sel),
            .en         (en),
            .data       (arb_data_in[k*DATA_WIDTH +: DATA_WIDTH]),
            .ready      (arb_ready_in[k]),
            .data_gated (data_gated[k])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++)
            sel_data = sel_data | data_gated[k];
    end

    assign xfer    = |(arb_valid_in & arb_ready_in);
    // In IDLE the accepted beat is the first of its grant
    assign at_last = (state == IDLE) ? (BURST_LEN == 1)
                                     : (beat_cnt == CNT_W'(BURST_LEN - 1));

    always_comb begin
        state_n = state;
        grant_n = grant_ch;
        rr_n    = rr_ptr;
        cnt_n   = beat_cnt;
        if (adv) begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_n = sel;
                        cnt_n   = CNT_W'(1);
                        if (BURST_LEN == 1)
                            rr_n = next_ch(sel);
                        else
                            state_n = BURST;
                    end
                end
                BURST: begin
                    if (arb_valid_in[grant_ch]) begin
                        cnt_n = beat_cnt + CNT_W'(1);
                        if (at_last) begin
                            state_n = IDLE;
                            rr_n    = next_ch(grant_ch);
                        end
                    end else begin
                        // Requester went quiet: give the grant up early
                        state_n = IDLE;
                        rr_n    = next_ch(grant_ch);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_ch <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            grant_ch <= grant_n;
            rr_ptr   <= rr_n;
            beat_cnt <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_valid_out <= 1'b0;
            arb_data_out  <= '0;
            arb_ch_out    <= '0;
            arb_last_out  <= 1'b0;
        end else if (adv) begin
            arb_valid_out <= xfer;
            if (xfer) begin
                arb_data_out <= sel_data;
                arb_ch_out   <= sel;
                arb_last_out <= at_last;
            end
        end
    end
endmodule
